// File: rtl/fse_adapt_ctrl.sv
// Adaptation sequencer for the FSE LMS tap-update engine: drives engine reset and
// shifter/tap strobes through IDLE, FILL, ADAPT and HOLD, and tracks convergence lock.
module fse_adapt_ctrl #(
  parameter int NUM_TAPS = 11,
  parameter int SHTR_DIV = 2,
  parameter int TAPS_DIV = 4,
  parameter int NBT_ERR  = 12,
  parameter int LOCK_CNT = 8,
  parameter int NB_CNT   = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_freeze,
  input  logic [NBT_ERR-1:0] i_err_I,
  input  logic [NBT_ERR-1:0] i_err_Q,
  input  logic [NBT_ERR-1:0] i_lock_thr,
  output logic               o_lms_reset,
  output logic               o_en_shtr,
  output logic               o_en_taps,
  output logic               o_locked,
  output logic               o_step_sel,
  output logic [1:0]         o_state
);

  localparam int PH_W = (TAPS_DIV > 1) ? $clog2(TAPS_DIV) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(TAPS_DIV - 1);
  localparam logic [NB_CNT-1:0] FILL_LAST = NB_CNT'(NUM_TAPS - 1);
  localparam logic [NB_CNT-1:0] LOCK_MAX  = NB_CNT'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ADAPT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d, ph_inc;
  logic [NB_CNT-1:0]   fill_q, fill_d;
  logic [NB_CNT-1:0]   good_q, good_d;
  logic [NB_CNT-1:0]   bad_q, bad_d;
  logic                locked_q, locked_d;
  logic                shtr_stb, taps_stb, upd_good;
  logic [NBT_ERR-1:0]  mag_i, mag_q;

  // Two's-complement magnitude kept at NBT_ERR bits, so the most negative code
  // reads as 2^(NBT_ERR-1) rather than wrapping back to itself as a negative.
  function automatic logic [NBT_ERR-1:0] err_mag(input logic [NBT_ERR-1:0] v);
    return v[NBT_ERR-1] ? (~v + NBT_ERR'(1)) : v;
  endfunction

  always_comb begin
    shtr_stb = (state_q != ST_IDLE) && ((int'(ph_q) % SHTR_DIV) == 0);
    taps_stb = (state_q == ST_ADAPT) && (ph_q == PH_LAST);
    mag_i    = err_mag(i_err_I);
    mag_q    = err_mag(i_err_Q);
    upd_good = (mag_i <= i_lock_thr) && (mag_q <= i_lock_thr);
    ph_inc   = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can leave a latch behind.
    state_d  = state_q;
    ph_d     = ph_q;
    fill_d   = fill_q;
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked_q;

    unique case (state_q)
      ST_IDLE: begin
        ph_d     = '0;
        fill_d   = '0;
        good_d   = '0;
        bad_d    = '0;
        locked_d = 1'b0;
        if (i_start) state_d = ST_FILL;
      end
      ST_FILL: begin
        ph_d = ph_inc;
        if (shtr_stb) begin
          fill_d = fill_q + NB_CNT'(1);
          if (fill_q == FILL_LAST) state_d = ST_ADAPT;
        end
      end
      ST_ADAPT: begin
        ph_d = ph_inc;
        if (taps_stb) begin
          if (upd_good) begin
            bad_d = '0;
            if (good_q != LOCK_MAX) good_d = good_q + NB_CNT'(1);
            if (good_d == LOCK_MAX) locked_d = 1'b1;
          end else begin
            good_d = '0;
            if (bad_q != LOCK_MAX) bad_d = bad_q + NB_CNT'(1);
            if (bad_d == LOCK_MAX) locked_d = 1'b0;
          end
        end
        if (i_freeze) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Phase keeps running so the tap grid survives the freeze.
        ph_d = ph_inc;
        if (!i_freeze) state_d = ST_ADAPT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_stop) begin
      state_d  = ST_IDLE;
      ph_d     = '0;
      fill_d   = '0;
      good_d   = '0;
      bad_d    = '0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only; blocking belongs in always_comb.
    if (i_reset) begin
      state_q  <= ST_IDLE;
      ph_q     <= '0;
      fill_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      fill_q   <= fill_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
    end
  end

  assign o_lms_reset = (state_q == ST_IDLE);
  assign o_en_shtr   = shtr_stb;
  assign o_en_taps   = taps_stb;
  assign o_locked    = locked_q;
  assign o_step_sel  = locked_q;
  assign o_state     = state_q;

endmodule
